// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - Zicsr read-modify-write sequencer over a bank of csr instances
// Optional CSR_B2B_EN: accept the next request in the same cycle as the response handshake.
module csr_access_unit #(
    parameter int                Width        = 32,
    parameter int                NumCsr       = 4,
    parameter logic [NumCsr-1:0] ReadOnlyMask = '0,
    localparam int               IdxW         = (NumCsr > 1) ? $clog2(NumCsr) : 1
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_op_i,
    input  logic [IdxW-1:0]          req_idx_i,
    input  logic [Width-1:0]         req_operand_i,
    input  logic                     req_rs1_zero_i,
    input  logic [NumCsr*Width-1:0]  csr_rd_data_i,
    output logic [NumCsr-1:0]        csr_wr_en_o,
    output logic [Width-1:0]         csr_wr_data_o,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [Width-1:0]         resp_rdata_o,
    output logic                     resp_illegal_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_e            state_q, state_d;
    logic [1:0]        op_q;
    logic [IdxW-1:0]   idx_q;
    logic [Width-1:0]  operand_q;
    logic              rs1_zero_q;
    logic [Width-1:0]  old_q;
    logic              illegal_q;
    logic [Width-1:0]  wr_data_q;

    logic              accept;
    logic              in_range;
    logic              ro_sel;
    logic              write_req;
    logic              illegal_c;
    logic              do_write;
    logic [Width-1:0]  old_sel;
    logic [Width-1:0]  wr_data_c;

    // One extra bit so an index equal to NumCsr is still representable in the compare.
    assign in_range  = {1'b0, idx_q} < (IdxW+1)'(NumCsr);
    assign write_req = (op_q == OP_RW) || !rs1_zero_q;
    assign illegal_c = (op_q == 2'b00) || !in_range || (ro_sel && write_req);
    assign do_write  = !illegal_c && write_req;
    assign accept    = req_valid_i && req_ready_o;

    always_comb begin
        old_sel = '0;
        ro_sel  = 1'b0;
        for (int i = 0; i < NumCsr; i++) begin
            if (idx_q == IdxW'(i)) begin
                old_sel = csr_rd_data_i[i*Width +: Width];
                ro_sel  = ReadOnlyMask[i];
            end
        end
    end

    always_comb begin
        wr_data_c = operand_q;
        case (op_q)
            OP_RS:   wr_data_c = old_sel | operand_q;
            OP_RC:   wr_data_c = old_sel & ~operand_q;
            default: wr_data_c = operand_q;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        state_d     = state_q;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = do_write ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
`ifdef CSR_B2B_EN
                req_ready_o = resp_ready_i;
`endif
                if (resp_ready_i) begin
                    state_d = accept ? ST_READ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            idx_q      <= '0;
            operand_q  <= '0;
            rs1_zero_q <= 1'b0;
            old_q      <= '0;
            illegal_q  <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= req_op_i;
                idx_q      <= req_idx_i;
                operand_q  <= req_operand_i;
                rs1_zero_q <= req_rs1_zero_i;
            end
            if (state_q == ST_READ) begin
                old_q     <= old_sel;
                illegal_q <= illegal_c;
                // Write data keeps its last value when no write follows.
                if (do_write) begin
                    wr_data_q <= wr_data_c;
                end
            end
        end
    end

    // Enable comes straight from the state register so reset removes it without waiting for a clock.
    always_comb begin
        csr_wr_en_o = '0;
        if (state_q == ST_WRITE) begin
            for (int i = 0; i < NumCsr; i++) begin
                if (idx_q == IdxW'(i)) begin
                    csr_wr_en_o[i] = 1'b1;
                end
            end
        end
    end

    assign csr_wr_data_o  = wr_data_q;
    assign resp_valid_o   = (state_q == ST_RESP);
    assign resp_illegal_o = (state_q == ST_RESP) && illegal_q;
    assign resp_rdata_o   = ((state_q == ST_RESP) && !illegal_q) ? old_q : '0;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - randomized self-checking bench for csr_access_unit against a csr-bank model
module tb_csr_access_unit;

    localparam int W    = 32;
    localparam int N    = 5;
    localparam int IW   = 3;
    localparam logic [N-1:0] RO_MASK = 5'b10000;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_op = '0;
    logic [IW-1:0]   req_idx = '0;
    logic [W-1:0]    req_operand = '0;
    logic            req_rs1_zero = 1'b0;
    logic [N*W-1:0]  rd_data;
    logic [N-1:0]    wr_en;
    logic [W-1:0]    wr_data;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [W-1:0]    resp_rdata;
    logic            resp_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_access_unit #(.Width(W), .NumCsr(N), .ReadOnlyMask(RO_MASK)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_idx_i      (req_idx),
        .req_operand_i  (req_operand),
        .req_rs1_zero_i (req_rs1_zero),
        .csr_rd_data_i  (rd_data),
        .csr_wr_en_o    (wr_en),
        .csr_wr_data_o  (wr_data),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_rdata_o   (resp_rdata),
        .resp_illegal_o (resp_illegal)
    );

    // csr instances driven by the unit, plus a preload port for the bench
    logic [W-1:0]  mem [N];
    logic          ld_en = 1'b0;
    logic [IW-1:0] ld_idx = '0;
    logic [W-1:0]  ld_val = '0;

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_val;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en[i]) mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) rd_data[i*W +: W] = mem[i];
    end

    logic [W-1:0] ref_mem [N];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load(input int idx, input logic [W-1:0] val);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = IW'(idx); ld_val = val;
        @(negedge clk);
        ld_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic do_op(input logic [1:0] op, input int idx, input logic [W-1:0] opnd,
                         input logic rz, input int hold);
        logic         illegal, wreq, write;
        logic [W-1:0] old, newv, exp_rdata;
        wreq    = (op == 2'b01) || !rz;
        illegal = (op == 2'b00) || (idx >= N) || (RO_MASK[idx % N] && wreq);
        write   = !illegal && wreq;
        old     = (idx < N) ? ref_mem[idx] : '0;
        case (op)
            2'b10:   newv = old | opnd;
            2'b11:   newv = old & ~opnd;
            default: newv = opnd;
        endcase
        exp_rdata = illegal ? '0 : old;

        @(negedge clk);
        chk("req_ready_idle", W'(req_ready), W'(1));
        req_valid = 1'b1; req_op = op; req_idx = IW'(idx);
        req_operand = opnd; req_rs1_zero = rz;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wr_en_read", W'(wr_en), '0);
        chk("resp_valid_read", W'(resp_valid), '0);
        if (write) begin
            @(posedge clk); #1;
            chk("wr_en_pulse", W'(wr_en), W'(1) << idx);
            chk("wr_data", wr_data, newv);
            chk("resp_valid_write", W'(resp_valid), '0);
            ref_mem[idx] = newv;
        end
        @(posedge clk); #1;
        chk("resp_valid", W'(resp_valid), W'(1));
        chk("wr_en_resp", W'(wr_en), '0);
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_illegal", W'(resp_illegal), W'(illegal));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", W'(resp_valid), W'(1));
            chk("hold_rdata", resp_rdata, exp_rdata);
            chk("hold_illegal", W'(resp_illegal), W'(illegal));
            chk("hold_req_ready", W'(req_ready), '0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #1;
`ifdef CSR_B2B_EN
        chk("release_req_ready", W'(req_ready), W'(1));
`else
        chk("release_req_ready", W'(req_ready), '0);
`endif
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_resp_valid", W'(resp_valid), '0);
        chk("post_req_ready", W'(req_ready), W'(1));
        for (int i = 0; i < N; i++) chk("csr_contents", mem[i], ref_mem[i]);
    endtask

    initial begin
        #1;
        chk("rst_req_ready", W'(req_ready), W'(1));
        chk("rst_resp_valid", W'(resp_valid), '0);
        chk("rst_wr_en", W'(wr_en), '0);
        chk("rst_wr_data", wr_data, '0);
        chk("rst_rdata", resp_rdata, '0);
        chk("rst_illegal", W'(resp_illegal), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        load(0, 32'h0000_000F);
        load(1, 32'h1234_5678);
        load(2, 32'h0000_1234);
        load(3, 32'h5555_AAAA);
        load(4, 32'h0000_ABCD);

        do_op(2'b01, 1, 32'hDEAD_BEEF, 1'b0, 0);
        do_op(2'b10, 0, 32'h0000_00F0, 1'b0, 0);
        do_op(2'b11, 2, 32'h0000_00FF, 1'b0, 0);
        do_op(2'b01, 4, 32'h0000_0001, 1'b0, 0);
        do_op(2'b10, 4, 32'h0000_0000, 1'b1, 0);
        do_op(2'b00, 1, 32'h0000_0003, 1'b0, 0);
        do_op(2'b01, 6, 32'h0000_0003, 1'b0, 0);
        do_op(2'b11, 3, 32'h0000_0000, 1'b1, 0);
        do_op(2'b01, 2, 32'hCAFE_F00D, 1'b0, 5);

        // reset while the write pulse is active
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_idx = 3'd3;
        req_operand = 32'h1111_2222; req_rs1_zero = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_wr_en", W'(wr_en), W'(5'b01000));
        rstn = 1'b0;
        #1;
        chk("rst_async_wr_en", W'(wr_en), '0);
        chk("rst_async_valid", W'(resp_valid), '0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk("rst_csr_kept", mem[3], ref_mem[3]);
        @(posedge clk); #1;
        chk("rst_after_valid", W'(resp_valid), '0);
        chk("rst_after_ready", W'(req_ready), W'(1));

        for (int k = 0; k < 40; k++) begin
            do_op(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom,
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
        end

`ifdef CSR_B2B_EN
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_idx = '0; req_rs1_zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b_resp1", W'(resp_valid), W'(1));
        @(negedge clk);
        resp_ready = 1'b1;
        #1;
        chk("b2b_ready", W'(req_ready), W'(1));
        @(posedge clk); #1;
        req_valid = 1'b0; resp_ready = 1'b0;
        chk("b2b_in_read", W'(resp_valid), '0);
        chk("b2b_read_ready", W'(req_ready), '0);
        @(posedge clk); #1;
        chk("b2b_resp2", W'(resp_valid), W'(1));
        chk("b2b_illegal2", W'(resp_illegal), W'(1));
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("b2b_done", W'(resp_valid), '0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
